// File: rtl/cpu_pkg.sv
// Shared definitions for the sequencer and datapath: opcodes, ALU pass-through
// codes, FSM states, IR field positions and the control-vector layout.
package cpu_pkg;

  localparam logic [3:0] OP_LDI = 4'h8;
  localparam logic [3:0] OP_LD  = 4'h9;
  localparam logic [3:0] OP_ST  = 4'hA;
  localparam logic [3:0] OP_JAL = 4'hB;
  localparam logic [3:0] OP_BZ  = 4'hC;
  localparam logic [3:0] OP_JR  = 4'hD;
  localparam logic [3:0] OP_NOP = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [3:0] FS_PASSA = 4'h8;
  localparam logic [3:0] FS_PASSB = 4'hC;

  localparam logic [15:0] IR_RESET = {OP_NOP, 12'h000};

  localparam int unsigned IR_OP_LSB = 12;
  localparam int unsigned IR_DR_LSB = 8;
  localparam int unsigned IR_SA_LSB = 4;
  localparam int unsigned IR_SB_LSB = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  typedef struct packed {
    logic [3:0] fs;
    logic       mb;
    logic       md;
    logic       mp;
    logic       rw;
    logic       mw;
  } ctrl_t;

  function automatic logic [3:0] ir_field(input logic [15:0] ir, input int unsigned lsb);
    return ir[lsb +: 4];
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational control decode: maps FSM state and opcode to the datapath
// control vector. Everything is zero outside EXEC and MEM.
module ctrl_decode
  import cpu_pkg::*;
(
  input  state_t     state,
  input  logic [3:0] op,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    if (state == S_MEM) begin
      ctrl.md = 1'b1;
      ctrl.rw = 1'b1;
    end else if (state == S_EXEC) begin
      if (!op[3]) begin
        ctrl.fs = {1'b0, op[2:0]};
        ctrl.rw = 1'b1;
      end else begin
        case (op)
          OP_LDI: begin
            ctrl.mb = 1'b1;
            ctrl.fs = FS_PASSB;
            ctrl.rw = 1'b1;
          end
          OP_ST:  ctrl.mw = 1'b1;
          OP_JAL: begin
            ctrl.mp = 1'b1;
            ctrl.rw = 1'b1;
          end
          OP_BZ:  ctrl.fs = FS_PASSA;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/execute controller: owns PC, IR and halt status and
// drives the datapath control lines from a registered control vector.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned     PC_W     = 6,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk_main,
  input  logic            reset,
  input  logic            run,
  input  logic [15:0]     instr_in,
  input  logic            Z,
  input  logic [15:0]     BusA,
  output logic [PC_W-1:0] InstrAddr,
  output logic [PC_W-1:0] PC,
  output logic [3:0]      DR,
  output logic [3:0]      SA,
  output logic [3:0]      SB,
  output logic [3:0]      FS,
  output logic            MB,
  output logic            MD,
  output logic            MP,
  output logic            RW,
  output logic            MW,
  output logic            halted
);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc;
  logic [15:0]     ir_q, ir_d;
  logic            halted_q, halted_d;
  ctrl_t           ctrl_q, ctrl_d;
  logic [3:0]      op, dr, sa, sb, op_d;

  assign op     = ir_field(ir_q, IR_OP_LSB);
  assign dr     = ir_field(ir_q, IR_DR_LSB);
  assign sa     = ir_field(ir_q, IR_SA_LSB);
  assign sb     = ir_field(ir_q, IR_SB_LSB);
  assign pc_inc = pc_q + PC_W'(1);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    halted_d = halted_q;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH:  state_d = run ? S_DECODE : S_IDLE;
      S_DECODE: begin
        ir_d    = instr_in;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_inc;
        case (op)
          OP_LD: begin
            state_d = S_MEM;
            pc_d    = pc_q;
          end
          OP_JAL: pc_d = PC_W'({sa, sb});
          OP_BZ:  if (Z) pc_d = PC_W'({dr, sb});
          OP_JR:  pc_d = PC_W'(BusA);
          OP_HLT: begin
            state_d  = S_HALT;
            pc_d     = pc_q;
            halted_d = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        state_d = S_FETCH;
        pc_d    = pc_inc;
      end
      S_HALT:  ;
      default: state_d = S_IDLE;
    endcase
  end

  // Controls are decoded from the next state/IR so they appear registered
  // in the same cycle the FSM enters EXEC or MEM.
  assign op_d = ir_field(ir_d, IR_OP_LSB);

  ctrl_decode u_ctrl_decode (
    .state (state_d),
    .op    (op_d),
    .ctrl  (ctrl_d)
  );

  always_ff @(posedge clk_main or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      ir_q     <= IR_RESET;
      halted_q <= 1'b0;
      ctrl_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      halted_q <= halted_d;
      ctrl_q   <= ctrl_d;
    end
  end

  assign InstrAddr = pc_q;
  assign PC        = pc_inc;
  assign DR        = dr;
  assign SA        = sa;
  assign SB        = sb;
  assign FS        = ctrl_q.fs;
  assign MB        = ctrl_q.mb;
  assign MD        = ctrl_q.md;
  assign MP        = ctrl_q.mp;
  assign RW        = ctrl_q.rw;
  assign MW        = ctrl_q.mw;
  assign halted    = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: directed ROM programs push expected
// control cycles; a monitor pops and compares whenever any control is active.
module tb_control_sequencer;

  typedef struct packed {
    logic [31:0] cyc;
    logic [5:0]  addr;
    logic [5:0]  pc;
    logic [3:0]  dr, sa, sb, fs;
    logic        mb, md, mp, rw, mw;
  } rec_t;

  logic        clk = 1'b0;
  logic        reset, run, z_in;
  logic [15:0] busa_in, rom_q;
  logic [5:0]  InstrAddr, PC;
  logic [3:0]  DR, SA, SB, FS;
  logic        MB, MD, MP, RW, MW, halted;

  logic [15:0] rom [64];
  rec_t        q[$];
  int          cyc;
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rom_q <= rom[InstrAddr];

  always @(posedge clk or negedge reset)
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;

  control_sequencer #(.PC_W(6), .RESET_PC(6'd0)) dut (
    .clk_main  (clk),
    .reset     (reset),
    .run       (run),
    .instr_in  (rom_q),
    .Z         (z_in),
    .BusA      (busa_in),
    .InstrAddr (InstrAddr),
    .PC        (PC),
    .DR        (DR),
    .SA        (SA),
    .SB        (SB),
    .FS        (FS),
    .MB        (MB),
    .MD        (MD),
    .MP        (MP),
    .RW        (RW),
    .MW        (MW),
    .halted    (halted)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push(input int c, input logic [5:0] a, input logic [15:0] ir,
                      input logic [3:0] fs, input logic mb, input logic md,
                      input logic mp, input logic rw, input logic mw);
    rec_t r;
    r.cyc = c; r.addr = a; r.pc = a + 6'd1;
    r.dr = ir[11:8]; r.sa = ir[7:4]; r.sb = ir[3:0]; r.fs = fs;
    r.mb = mb; r.md = md; r.mp = mp; r.rw = rw; r.mw = mw;
    q.push_back(r);
  endtask

  task automatic wait_cyc(input int n);
    for (int i = 0; i < 300 && cyc != n; i++) @(negedge clk);
    if (cyc != n) chk($sformatf("reach_cyc%0d", n), cyc, n);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = 16'hE000;
  endtask

  task automatic start(input logic run_v);
    @(negedge clk);
    reset = 1'b0;
    run   = run_v;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
    #1;
    chk(name, q.size(), 0);
  endtask

  // Monitor: a cycle with any active control is one observed output.
  initial begin
    rec_t act, e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && (RW || MW || MB || MD || MP || FS != 4'h0)) begin
        act.cyc = cyc; act.addr = InstrAddr; act.pc = PC;
        act.dr = DR; act.sa = SA; act.sb = SB; act.fs = FS;
        act.mb = MB; act.md = MD; act.mp = MP; act.rw = RW; act.mw = MW;
        n_checks++;
        if (q.size() == 0) begin
          $display("FAIL unexpected_ctrl: got %h expected none", act);
        end else begin
          e = q.pop_front();
          if (act === e) n_pass++;
          else $display("FAIL ctrl_cyc%0d: got %h expected %h", e.cyc, act, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; run = 1'b0; z_in = 1'b0; busa_in = 16'h0000;
    clear_rom();

    // Reset asserted mid-EXEC of an ALU op drops RW at once.
    rom[0] = 16'h0123; rom[1] = 16'h0456;
    push(3, 6'h00, 16'h0123, 4'h0, 0, 0, 0, 1, 0);
    push(6, 6'h01, 16'h0456, 4'h0, 0, 0, 0, 1, 0);
    start(1'b1);
    wait_cyc(6);
    #2 reset = 1'b0;
    #1;
    chk("rst_rw_async", RW, 1'b0);
    chk("rst_mw", MW, 1'b0);
    chk("rst_fs", FS, 4'h0);
    chk("rst_addr", InstrAddr, 6'h00);
    chk("rst_ir_fields", {DR, SA, SB}, 12'h000);
    chk("rst_halted", halted, 1'b0);
    drain("drain_rst");

    // LDI, ALU, LD, ST, ALU op7, NOP, HLT.
    clear_rom();
    rom[0] = 16'h8A35; rom[1] = 16'h0B1A; rom[2] = 16'h9210; rom[3] = 16'hA045;
    rom[4] = 16'h7123; rom[5] = 16'hE000; rom[6] = 16'hF000;
    push(3,  6'h00, 16'h8A35, 4'hC, 1, 0, 0, 1, 0);
    push(6,  6'h01, 16'h0B1A, 4'h0, 0, 0, 0, 1, 0);
    push(10, 6'h02, 16'h9210, 4'h0, 0, 1, 0, 1, 0);
    push(13, 6'h03, 16'hA045, 4'h0, 0, 0, 0, 0, 1);
    push(16, 6'h04, 16'h7123, 4'h7, 0, 0, 0, 1, 0);
    start(1'b1);
    wait_cyc(7);  chk("pc_after_6", InstrAddr, 6'h02);
    wait_cyc(9);  chk("ld_exec_rw", RW, 1'b0);
    wait_cyc(11); chk("ld_next_fetch", InstrAddr, 6'h03);
    wait_cyc(22); chk("hlt_exec_not_halted", halted, 1'b0);
    wait_cyc(24);
    chk("hlt_halted", halted, 1'b1);
    chk("hlt_addr", InstrAddr, 6'h06);
    run = 1'b0; repeat (3) @(negedge clk);
    run = 1'b1; repeat (3) @(negedge clk);
    chk("hlt_sticky", halted, 1'b1);
    chk("hlt_addr_hold", InstrAddr, 6'h06);
    drain("drain_prog_a");

    // Branches: BZ taken, JAL with wrap, JR, BZ not taken.
    clear_rom();
    rom[6'h00] = 16'hC532; rom[6'h12] = 16'hB03F; rom[6'h3F] = 16'hB70C;
    rom[6'h0C] = 16'hD000; rom[6'h23] = 16'hC010; rom[6'h24] = 16'h0456;
    rom[6'h25] = 16'hF000;
    z_in = 1'b1; busa_in = 16'h0123;
    push(3,  6'h00, 16'hC532, 4'h8, 0, 0, 0, 0, 0);
    push(6,  6'h12, 16'hB03F, 4'h0, 0, 0, 1, 1, 0);
    push(9,  6'h3F, 16'hB70C, 4'h0, 0, 0, 1, 1, 0);
    push(15, 6'h23, 16'hC010, 4'h8, 0, 0, 0, 0, 0);
    push(18, 6'h24, 16'h0456, 4'h0, 0, 0, 0, 1, 0);
    start(1'b1);
    wait_cyc(4);  chk("bz_taken", InstrAddr, 6'h12);
    z_in = 1'b0;
    wait_cyc(9);  chk("jal_link_wrap", PC, 6'h00);
    wait_cyc(10); chk("jal_target", InstrAddr, 6'h0C);
    wait_cyc(13); chk("jr_target", InstrAddr, 6'h23);
    wait_cyc(16); chk("bz_not_taken", InstrAddr, 6'h24);
    wait_cyc(23); chk("prog_b_halted", halted, 1'b1);
    drain("drain_prog_b");

    // run dropped during DECODE: instruction completes, then parks.
    clear_rom();
    z_in = 1'b0;
    rom[0] = 16'h0123; rom[1] = 16'h0456; rom[2] = 16'hF000;
    push(3,  6'h00, 16'h0123, 4'h0, 0, 0, 0, 1, 0);
    push(15, 6'h01, 16'h0456, 4'h0, 0, 0, 0, 1, 0);
    start(1'b1);
    wait_cyc(2);  run = 1'b0;
    wait_cyc(6);  chk("idle_addr_hold", InstrAddr, 6'h01);
    wait_cyc(12);
    chk("idle_addr_hold_late", InstrAddr, 6'h01);
    chk("idle_not_halted", halted, 1'b0);
    run = 1'b1;
    wait_cyc(16); chk("resume_addr", InstrAddr, 6'h02);
    wait_cyc(19); chk("resume_halted", halted, 1'b1);
    drain("drain_prog_c");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
